// File: rtl/pri_arb8_ctrl_pkg.sv
// Shared definitions for the 8-requester priority arbiter: sizes, FSM
// state encoding and the highest-set-bit helper used by the picker.
package pri_arb8_ctrl_pkg;

    localparam int N_REQ            = 8;
    localparam int IDX_W            = 3;
    localparam int CNT_W            = 4;
    localparam int MAX_HOLD_DEFAULT = 15;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RECOVER = 2'd2
    } state_t;

    // Index of the highest set bit of v; zero when v is all-zero.
    function automatic logic [IDX_W-1:0] highest_bit(input logic [N_REQ-1:0] v);
        logic [IDX_W-1:0] res;
        res = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (v[i]) begin
                res = IDX_W'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pri_arb8_ctrl_if.sv
// Request/grant bundle between the requesters (master side) and the
// arbiter (slave side).
interface pri_arb8_ctrl_if;
    import pri_arb8_ctrl_pkg::*;

    logic [N_REQ-1:0] req;
    logic             rr_en;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic             timeout;

    modport master (
        output req, rr_en,
        input  gnt, gnt_idx, gnt_vld, timeout
    );

    modport slave (
        input  req, rr_en,
        output gnt, gnt_idx, gnt_vld, timeout
    );

endinterface

// File: rtl/pri_arb8_ctrl_pick.sv
// Combinational winner selection. In round-robin mode only requesters
// below the previous winner are considered first; if none of them is
// asking, selection falls back to the plain highest-index request.
module pri_pick_mask8
    import pri_arb8_ctrl_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             rr_en,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [N_REQ-1:0] mask;
    logic [N_REQ-1:0] masked_req;

    // Build the below-pointer mask and pick the highest eligible request.
    always_comb begin
        mask       = (N_REQ'(1) << ptr) - N_REQ'(1);
        masked_req = req & mask;
        any        = |req;
        if (rr_en && (|masked_req)) begin
            idx = highest_bit(masked_req);
        end else begin
            idx = highest_bit(req);
        end
    end

endmodule

// File: rtl/pri_arb8_ctrl.sv
// Registered 8-requester arbiter. A grant is held while the winner keeps
// its request up, optionally cut short by a hold timer, and is always
// followed by a one-cycle turnaround before the next arbitration.
module pri_arb8_ctrl
    import pri_arb8_ctrl_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    pri_arb8_ctrl_if.slave    bus
);

    state_t           state_q,   state_d;
    logic [IDX_W-1:0] ptr_q,     ptr_d;
    logic [CNT_W-1:0] timer_q,   timer_d;
    logic [N_REQ-1:0] gnt_q,     gnt_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic             gnt_vld_q, gnt_vld_d;
    logic             timeout_q, timeout_d;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             hold_expired;

    pri_pick_mask8 u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .rr_en (bus.rr_en),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // A hold limit of zero disables forced revocation entirely.
    assign hold_expired = (MAX_HOLD != 0) && (timer_q == CNT_W'(MAX_HOLD));

    // Next-state logic: arbitrate in IDLE, supervise the grant, then turn around.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        timer_d   = timer_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        gnt_vld_d = gnt_vld_q;
        timeout_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                gnt_d     = '0;
                gnt_idx_d = '0;
                gnt_vld_d = 1'b0;
                timer_d   = '0;
                if (pick_any) begin
                    state_d   = S_GRANT;
                    gnt_d     = N_REQ'(1) << pick_idx;
                    gnt_idx_d = pick_idx;
                    gnt_vld_d = 1'b1;
                    timer_d   = CNT_W'(1);
                end
            end

            S_GRANT: begin
                if (!bus.req[gnt_idx_q] || hold_expired) begin
                    state_d   = S_RECOVER;
                    ptr_d     = gnt_idx_q;
                    gnt_d     = '0;
                    gnt_idx_d = '0;
                    gnt_vld_d = 1'b0;
                    timeout_d = bus.req[gnt_idx_q];
                end else if (timer_q != '1) begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end

            S_RECOVER: begin
                state_d = S_IDLE;
                timer_d = '0;
            end

            default: begin
                state_d   = S_IDLE;
                gnt_d     = '0;
                gnt_idx_d = '0;
                gnt_vld_d = 1'b0;
                timer_d   = '0;
            end
        endcase
    end

    // State and output registers; reset clears the grant without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            timer_q   <= '0;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            gnt_vld_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            timer_q   <= timer_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_vld_q <= gnt_vld_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_idx = gnt_idx_q;
    assign bus.gnt_vld = gnt_vld_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_pri_arb8_ctrl.sv
// Scoreboard bench for pri_arb8_ctrl: stimulus queues the grants it expects,
// a negedge monitor checks every grant the arbiter actually issues.
module tb_pri_arb8_ctrl;

    typedef struct {
        int   idx;
        int   gap;
        int   len;
        logic to;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   passes;
    int   high_cnt;
    int   low_cnt;
    logic prev_vld;
    exp_t exp_q[$];

    pri_arb8_ctrl_if bus ();
    pri_arb8_ctrl_if bus0 ();

    pri_arb8_ctrl #(.MAX_HOLD(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    pri_arb8_ctrl #(.MAX_HOLD(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something upstream never terminates.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    task automatic expectGrant(input int idx, input int gap, input int len, input logic to);
        exp_t e;
        e.idx = idx;
        e.gap = gap;
        e.len = len;
        e.to  = to;
        exp_q.push_back(e);
    endtask

    // Reactive requesters: each winner drops its bit after holds[g] grant
    // cycles (0 = never) and re-raises it once the grant has ended.
    task automatic applyStimulus(input logic [7:0] pattern, input logic rr,
                                 input int holds[4], input int n);
        int   g;
        int   cnt;
        int   guard;
        logic prev;
        g     = 0;
        cnt   = 0;
        guard = 0;
        prev  = 1'b0;
        bus.rr_en = rr;
        bus.req   = pattern;
        while (g < n && guard < 400) begin
            @(negedge clk);
            guard++;
            if (bus.gnt_vld) begin
                cnt++;
                if (holds[g] != 0 && cnt == holds[g]) begin
                    bus.req = pattern & ~(8'b1 << bus.gnt_idx);
                end
            end else if (prev) begin
                g++;
                cnt = 0;
                bus.req = (g < n) ? pattern : 8'h00;
            end
            prev = bus.gnt_vld;
        end
        if (g < n) begin
            checkOutput("grant_sequence_timeout", g, n);
            bus.req = 8'h00;
        end
    endtask

    // Monitor: on each grant start compare winner and gap, on each grant end
    // compare its length and whether it was a forced revoke.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.gnt_vld && !prev_vld) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_grant_idx", int'(bus.gnt_idx), -1);
            end else begin
                e = exp_q[0];
                checkOutput("grant_idx", int'(bus.gnt_idx), e.idx);
                checkOutput("grant_onehot", int'(bus.gnt), 1 << e.idx);
                if (e.gap >= 0) begin
                    checkOutput("gap_cycles", low_cnt, e.gap);
                end
            end
            high_cnt = 1;
        end else if (bus.gnt_vld) begin
            high_cnt++;
        end else if (prev_vld) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_grant_end", high_cnt, -1);
            end else begin
                e = exp_q.pop_front();
                checkOutput("grant_len", high_cnt, e.len);
                checkOutput("timeout_at_end", int'(bus.timeout), int'(e.to));
            end
            low_cnt = 1;
        end else begin
            low_cnt++;
            checkOutput("timeout_idle", int'(bus.timeout), 0);
        end
        prev_vld = bus.gnt_vld;
    end

    initial begin
        int held;
        int guard;
        checks    = 0;
        passes    = 0;
        high_cnt  = 0;
        low_cnt   = 0;
        prev_vld  = 1'b0;
        rst       = 1'b1;
        bus.req   = 8'hFF;
        bus.rr_en = 1'b0;
        bus0.req  = 8'h00;
        bus0.rr_en = 1'b0;

        // Reset holds everything off even with every request up.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_gnt", int'(bus.gnt), 0);
        checkOutput("reset_gnt_vld", int'(bus.gnt_vld), 0);
        checkOutput("reset_timeout", int'(bus.timeout), 0);
        checkOutput("reset_gnt_idx", int'(bus.gnt_idx), 0);
        expectGrant(7, -1, 1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("first_gnt", int'(bus.gnt), 8'h80);
        checkOutput("first_gnt_idx", int'(bus.gnt_idx), 7);
        @(negedge clk);
        bus.req = 8'h00;
        repeat (4) @(negedge clk);

        // Fixed priority: bit 0 is starved.
        $display("[TB] fixed priority");
        expectGrant(7, -1, 3, 1'b0);
        expectGrant(7, 2, 3, 1'b0);
        expectGrant(7, 2, 3, 1'b0);
        applyStimulus(8'h81, 1'b0, '{3, 3, 3, 0}, 3);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Round robin from a fresh pointer alternates 7 and 0.
        $display("[TB] round robin");
        expectGrant(7, -1, 3, 1'b0);
        expectGrant(0, 2, 3, 1'b0);
        expectGrant(7, 2, 3, 1'b0);
        expectGrant(0, 2, 3, 1'b0);
        applyStimulus(8'h81, 1'b1, '{3, 3, 3, 3}, 4);
        repeat (3) @(negedge clk);

        // Hold timeout, then regrant to the still-requesting owner.
        $display("[TB] hold timeout");
        expectGrant(4, -1, 15, 1'b1);
        expectGrant(4, 2, 2, 1'b0);
        applyStimulus(8'h10, 1'b0, '{0, 2, 0, 0}, 2);

        // Release coinciding with the limit is a normal release.
        expectGrant(4, -1, 15, 1'b0);
        applyStimulus(8'h10, 1'b0, '{15, 0, 0, 0}, 1);
        repeat (3) @(negedge clk);

        // Timeout disabled: the grant must survive 100 cycles.
        bus0.req = 8'h10;
        held = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus0.gnt_vld && bus0.gnt == 8'h10 && !bus0.timeout) begin
                held++;
            end
        end
        checkOutput("no_timeout_held_cycles", held, 100);
        bus0.req = 8'h00;
        repeat (3) @(negedge clk);

        // Asynchronous reset in the middle of a grant to requester 3.
        $display("[TB] async reset mid-grant");
        expectGrant(3, -1, 4, 1'b0);
        bus.rr_en = 1'b1;
        bus.req   = 8'h08;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!bus.gnt_vld && guard < 20);
        checkOutput("rr_grant_seen", int'(bus.gnt_vld), 1);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_gnt", int'(bus.gnt), 0);
        checkOutput("async_rst_gnt_vld", int'(bus.gnt_vld), 0);
        bus.req = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        expectGrant(7, -1, 2, 1'b0);
        expectGrant(3, 2, 2, 1'b0);
        applyStimulus(8'h88, 1'b1, '{2, 2, 0, 0}, 2);

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
